fetch_decode: RTL and testbench

Instruction fetch and decode stage directly upstream of the CPU controller. It holds the fetch PC and prefetches up to DEPTH words from instruction memory into a small in-order buffer. On the controller's load_ir pulse it moves the head word into the instruction register (IR) and presents decoded fields: opcode, cond, register addresses and immediates. The controller and datapath consume those fields; the controller's load_pc/clear_pc redirect fetch.

---
 rtl/fetch_decode_if.sv | 25 ++
 rtl/fetch_decode.sv | 229 ++++++++++++++++++++++
 tb/tb_fetch_decode.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_if.sv
// Instruction memory read bus between the fetch stage and instruction memory.
// The fetch stage is the master: it issues word-aligned read requests and
// consumes in-order read responses.
interface fetch_decode_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_decode.sv
// Instruction fetch and decode stage. Prefetches up to DEPTH words into an
// in-order buffer, moves the head word into the instruction register on
// load_ir, and presents registered decode fields to the controller.
// load_pc/clear_pc redirect fetch and discard responses already in flight.
module fetch_decode #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    fetch_decode_if.master    imem,
    input  logic              load_ir,
    input  logic              load_pc,
    input  logic              clear_pc,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              buf_empty,
    output logic [6:0]        opcode,
    output logic [3:0]        cond,
    output logic [3:0]        rn,
    output logic [3:0]        rd,
    output logic [3:0]        rs,
    output logic [3:0]        rm,
    output logic [11:0]       imm12,
    output logic [4:0]        imm5,
    output logic [1:0]        shift_type
);

    localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]       NOP_WORD  = 32'hE320F000;
    localparam logic [31:0]       HLT_WORD  = 32'hE1000070;
    localparam logic [6:0]        OP_NOP    = 7'b1000000;
    localparam logic [6:0]        OP_HLT    = 7'b1000001;
    localparam logic [6:0]        OP_UNDEF  = 7'b1111111;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]       buf_data_q [DEPTH];
    logic [31:0]       buf_data_d [DEPTH];
    logic [ADDR_W-1:0] buf_pc_q   [DEPTH];
    logic [ADDR_W-1:0] buf_pc_d   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic [6:0]        opcode_q, opcode_d;

    logic              flush;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              rsp;
    logic              rsp_live;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] target_pc;
    logic              do_pop;
    logic              do_bypass;
    logic              do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // The specific NOP/HLT encodings are checked first; otherwise only the
    // listed data-processing operations are defined.
    function automatic logic [6:0] decode_op(input logic [31:0] word);
        logic [6:0] op;
        logic       dp;
        logic [2:0] alu;
        logic       uses_rn;
        dp      = 1'b1;
        alu     = 3'b000;
        uses_rn = 1'b1;
        case (word[24:21])
            4'b0100: alu = 3'b000;
            4'b0010: alu = 3'b001;
            4'b1010: alu = 3'b010;
            4'b0000: alu = 3'b011;
            4'b1100: alu = 3'b100;
            4'b0001: alu = 3'b101;
            4'b1101: begin
                alu     = 3'b000;
                uses_rn = 1'b0;
            end
            default: dp = 1'b0;
        endcase
        if (word == NOP_WORD) begin
            op = OP_NOP;
        end else if (word == HLT_WORD) begin
            op = OP_HLT;
        end else if (dp && (word[27:26] == 2'b00)) begin
            op = {1'b0, (!word[25] && word[4]), !word[25], uses_rn, alu};
        end else begin
            op = OP_UNDEF;
        end
        return op;
    endfunction

    // A response only counts while a request is outstanding, so stray data
    // from before a reset cannot corrupt the counters. The oldest live request
    // sits 4*outstanding bytes behind the fetch PC because issue is sequential.
    always_comb begin
        flush     = load_pc || clear_pc;
        occupancy = {1'b0, count_q} + {1'b0, outstanding_q};
        issue     = !rst && !flush && (occupancy < DEPTH_OCC);
        rsp       = imem.imem_rvalid && (outstanding_q != '0);
        rsp_live  = rsp && (drop_q == '0);
        resp_pc   = fetch_pc_q - ADDR_W'({outstanding_q, 2'b00});
        target_pc = pc_in & ~ADDR_W'(3);
        do_pop    = load_ir && !flush && (count_q != '0);
        do_bypass = load_ir && !flush && (count_q == '0) && rsp_live;
        do_push   = rsp_live && !flush && !do_bypass;
    end

    // Next-state for fetch PC, request accounting, prefetch buffer and IR.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        buf_data_d    = buf_data_q;
        buf_pc_d      = buf_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        opcode_d      = opcode_q;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
        if (issue && !rsp) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!issue && rsp) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        if (flush) begin
            fetch_pc_d = clear_pc ? RESET_PC : target_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_d     = rsp ? (outstanding_q - 1'b1) : outstanding_q;
        end else begin
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (do_pop) begin
                ir_d       = buf_data_q[rd_ptr_q];
                ir_pc_d    = buf_pc_q[rd_ptr_q];
                ir_valid_d = 1'b1;
                opcode_d   = decode_op(buf_data_q[rd_ptr_q]);
                rd_ptr_d   = next_ptr(rd_ptr_q);
            end else if (do_bypass) begin
                ir_d       = imem.imem_rdata;
                ir_pc_d    = resp_pc;
                ir_valid_d = 1'b1;
                opcode_d   = decode_op(imem.imem_rdata);
            end
            if (do_push) begin
                buf_data_d[wr_ptr_q] = imem.imem_rdata;
                buf_pc_d[wr_ptr_q]   = resp_pc;
                wr_ptr_d             = next_ptr(wr_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers; reset leaves the IR decoding as NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            ir_q          <= '0;
            ir_pc_q       <= '0;
            ir_valid_q    <= 1'b0;
            opcode_q      <= OP_NOP;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            buf_data_q    <= buf_data_d;
            buf_pc_q      <= buf_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            opcode_q      <= opcode_d;
        end
    end

    assign imem.imem_req  = issue;
    assign imem.imem_addr = fetch_pc_q;
    assign buf_empty      = (count_q == '0) && !rsp_live;
    assign ir_valid       = ir_valid_q;
    assign ir_pc          = ir_pc_q;
    assign opcode         = opcode_q;
    assign cond           = ir_q[31:28];
    assign rn             = ir_q[19:16];
    assign rd             = ir_q[15:12];
    assign rs             = ir_q[11:8];
    assign rm             = ir_q[3:0];
    assign imm12          = ir_q[11:0];
    assign imm5           = ir_q[11:7];
    assign shift_type     = ir_q[6:5];

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: an in-order instruction memory model
// with adjustable latency, hand-written multi-cycle sequences, and a table of
// instruction words with hand-decoded fields.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_ir;
    logic        load_pc;
    logic        clear_pc;
    logic [31:0] pc_in;
    logic        ir_valid;
    logic [31:0] ir_pc;
    logic        buf_empty;
    logic [6:0]  opcode;
    logic [3:0]  cond, rn, rd, rs, rm;
    logic [11:0] imm12;
    logic [4:0]  imm5;
    logic [1:0]  shift_type;

    int checks   = 0;
    int failures = 0;

    fetch_decode_if #(.ADDR_W(32)) mif ();

    fetch_decode #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (mif),
        .load_ir    (load_ir),
        .load_pc    (load_pc),
        .clear_pc   (clear_pc),
        .pc_in      (pc_in),
        .ir_valid   (ir_valid),
        .ir_pc      (ir_pc),
        .buf_empty  (buf_empty),
        .opcode     (opcode),
        .cond       (cond),
        .rn         (rn),
        .rd         (rd),
        .rs         (rs),
        .rm         (rm),
        .imm12      (imm12),
        .imm5       (imm5),
        .shift_type (shift_type)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    int          lat = 1;
    int          ncyc = 0;
    int          max_inflight = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] addr_log  [$];
    logic [31:0] mem_ovr   [logic [31:0]];

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a;
    endfunction

    // Memory model: drive responses right after the falling edge, then sample
    // the settled request a little later; each word defaults to its address.
    initial begin
        mif.imem_rvalid = 1'b0;
        mif.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                mif.imem_rvalid = 1'b0;
            end else if (pend_addr.size() > 0 && pend_due[0] <= ncyc) begin
                mif.imem_rvalid = 1'b1;
                mif.imem_rdata  = memRead(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                mif.imem_rvalid = 1'b0;
                mif.imem_rdata  = 32'hDEADBEEF;
            end
            #3;
            if (!rst && mif.imem_req) begin
                pend_addr.push_back(mif.imem_addr);
                pend_due.push_back(ncyc + lat);
                addr_log.push_back(mif.imem_addr);
            end
            if (pend_addr.size() + (mif.imem_rvalid ? 1 : 0) > max_inflight)
                max_inflight = pend_addr.size() + (mif.imem_rvalid ? 1 : 0);
        end
    end

    // Hard stop in case a sequence stalls beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: actual=timeout required=event within bound", name);
    endtask

    task automatic waitNotEmpty(input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            #2;
            if (!buf_empty) ok = 1'b1;
        end
        if (!ok) reportTimeout(name);
    endtask

    task automatic loadWhenReady(input string name, output bit rv_seen);
        bit ok;
        rv_seen = 1'b0;
        waitNotEmpty(name, ok);
        if (ok) begin
            rv_seen = mif.imem_rvalid;
            load_ir = 1'b1;
            @(negedge clk);
            #2;
            load_ir = 1'b0;
        end
    endtask

    task automatic waitNewAddr(input string name, input int base, output logic [31:0] a);
        bit ok;
        ok = 1'b0;
        a  = 32'hFFFFFFFF;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            #4;
            if (addr_log.size() > base) begin
                a  = addr_log[base];
                ok = 1'b1;
            end
        end
        if (!ok) reportTimeout(name);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [6:0]  op;
        logic [3:0]  cnd;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rm;
        logic [11:0] imm12;
        logic [4:0]  imm5;
        logic [1:0]  sh;
    } vec_t;

    vec_t vecs [12];

    // Redirect fetch to a target holding the vector word, load it, check fields.
    task automatic applyStimulus(input vec_t v, input logic [31:0] target);
        bit rv;
        mem_ovr[target] = v.word;
        @(negedge clk);
        #2;
        pc_in   = target + 32'h3;
        load_pc = 1'b1;
        @(negedge clk);
        #2;
        load_pc = 1'b0;
        loadWhenReady("vec_load", rv);
        checkOutput("vec_ir_valid", {31'b0, ir_valid}, 32'h1);
        checkOutput("vec_ir_pc", ir_pc, target);
        checkOutput("vec_opcode", {25'b0, opcode}, {25'b0, v.op});
        checkOutput("vec_cond", {28'b0, cond}, {28'b0, v.cnd});
        checkOutput("vec_rn", {28'b0, rn}, {28'b0, v.rn});
        checkOutput("vec_rd", {28'b0, rd}, {28'b0, v.rd});
        checkOutput("vec_rs", {28'b0, rs}, {28'b0, v.rs});
        checkOutput("vec_rm", {28'b0, rm}, {28'b0, v.rm});
        checkOutput("vec_imm12", {20'b0, imm12}, {20'b0, v.imm12});
        checkOutput("vec_imm5", {27'b0, imm5}, {27'b0, v.imm5});
        checkOutput("vec_shift", {30'b0, shift_type}, {30'b0, v.sh});
    endtask

    // Main sequence: reset, streaming, flush, combined redirect, bypass,
    // mid-fetch reset, then the decode table.
    initial begin
        logic [31:0] a;
        bit          rv;
        bit          ok;
        int          base;

        vecs[0]  = '{32'hE0812003, 7'h18, 4'hE, 4'h1, 4'h2, 4'h0, 4'h3, 12'h003, 5'h00, 2'd0};
        vecs[1]  = '{32'hE3A0000A, 7'h00, 4'hE, 4'h0, 4'h0, 4'h0, 4'hA, 12'h00A, 5'h00, 2'd0};
        vecs[2]  = '{32'hE35100FF, 7'h0A, 4'hE, 4'h1, 4'h0, 4'h0, 4'hF, 12'h0FF, 5'h01, 2'd3};
        vecs[3]  = '{32'hE1000070, 7'h41, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 12'h070, 5'h00, 2'd3};
        vecs[4]  = '{32'hFFFFFFFF, 7'h7F, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 12'hFFF, 5'h1F, 2'd3};
        vecs[5]  = '{32'hE320F000, 7'h40, 4'hE, 4'h0, 4'hF, 4'h0, 4'h0, 12'h000, 5'h00, 2'd0};
        vecs[6]  = '{32'hE0412335, 7'h39, 4'hE, 4'h1, 4'h2, 4'h3, 4'h5, 12'h335, 5'h06, 2'd1};
        vecs[7]  = '{32'hF3812004, 7'h0C, 4'hF, 4'h1, 4'h2, 4'h0, 4'h4, 12'h004, 5'h00, 2'd0};
        vecs[8]  = '{32'hE0212003, 7'h1D, 4'hE, 4'h1, 4'h2, 4'h0, 4'h3, 12'h003, 5'h00, 2'd0};
        vecs[9]  = '{32'hE0000000, 7'h1B, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 5'h00, 2'd0};
        vecs[10] = '{32'hE5912000, 7'h7F, 4'hE, 4'h1, 4'h2, 4'h0, 4'h0, 12'h000, 5'h00, 2'd0};
        vecs[11] = '{32'hE1100000, 7'h7F, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 5'h00, 2'd0};

        rst      = 1'b1;
        load_ir  = 1'b0;
        load_pc  = 1'b0;
        clear_pc = 1'b0;
        pc_in    = 32'h0;
        lat      = 1;

        // Reset values
        @(negedge clk);
        #2;
        checkOutput("rst_imem_req", {31'b0, mif.imem_req}, 32'h0);
        checkOutput("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
        checkOutput("rst_ir_pc", ir_pc, 32'h0);
        checkOutput("rst_opcode", {25'b0, opcode}, 32'h40);
        checkOutput("rst_cond", {28'b0, cond}, 32'h0);
        checkOutput("rst_rd", {28'b0, rd}, 32'h0);
        checkOutput("rst_imm12", {20'b0, imm12}, 32'h0);
        checkOutput("rst_shift", {30'b0, shift_type}, 32'h0);
        checkOutput("rst_buf_empty", {31'b0, buf_empty}, 32'h1);

        // Streaming with 1-cycle memory, load_ir every third cycle
        addr_log.delete();
        max_inflight = 0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (2) @(negedge clk);
            #2;
            load_ir = 1'b1;
            @(negedge clk);
            #2;
            load_ir = 1'b0;
            checkOutput("stream_ir_valid", {31'b0, ir_valid}, 32'h1);
            checkOutput("stream_ir_pc", ir_pc, 32'(k * 4));
            checkOutput("stream_imm12", {20'b0, imm12}, 32'(k * 4));
        end
        if (addr_log.size() >= 3) begin
            checkOutput("stream_addr0", addr_log[0], 32'h0);
            checkOutput("stream_addr1", addr_log[1], 32'h4);
            checkOutput("stream_addr2", addr_log[2], 32'h8);
        end else begin
            reportTimeout("stream_addr_count");
        end
        checkOutput("stream_max_inflight_le2", {31'b0, (max_inflight <= 2)}, 32'h1);

        // Two outstanding requests, then redirect to 0x103
        @(negedge clk);
        #2;
        rst = 1'b1;
        lat = 4;
        repeat (2) @(negedge clk);
        #2;
        addr_log.delete();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("flush_pre_issued", addr_log.size(), 32'h2);
        checkOutput("flush_pre_pending", pend_addr.size(), 32'h2);
        base    = addr_log.size();
        pc_in   = 32'h103;
        load_pc = 1'b1;
        @(negedge clk);
        #2;
        load_pc = 1'b0;
        waitNewAddr("flush_next_addr", base, a);
        checkOutput("flush_next_addr", a, 32'h100);
        loadWhenReady("flush_first_ir", rv);
        checkOutput("flush_ir_pc", ir_pc, 32'h100);
        checkOutput("flush_imm12", {20'b0, imm12}, 32'h100);
        checkOutput("flush_opcode", {25'b0, opcode}, 32'h1B);

        // load_pc + clear_pc + load_ir together: RESET_PC wins, IR retained
        waitNotEmpty("both_wait", ok);
        base     = addr_log.size();
        pc_in    = 32'h2000;
        load_pc  = 1'b1;
        clear_pc = 1'b1;
        load_ir  = 1'b1;
        @(negedge clk);
        #2;
        load_pc  = 1'b0;
        clear_pc = 1'b0;
        load_ir  = 1'b0;
        checkOutput("both_ir_valid", {31'b0, ir_valid}, 32'h1);
        checkOutput("both_ir_pc", ir_pc, 32'h100);
        checkOutput("both_imm12", {20'b0, imm12}, 32'h100);
        checkOutput("both_opcode", {25'b0, opcode}, 32'h1B);
        waitNewAddr("both_next_addr", base, a);
        checkOutput("both_next_addr", a, 32'h0);

        // Empty buffer, load_ir on the response cycle: bypass into IR
        @(negedge clk);
        #2;
        pc_in   = 32'h300;
        load_pc = 1'b1;
        @(negedge clk);
        #2;
        load_pc = 1'b0;
        loadWhenReady("bypass_load", rv);
        checkOutput("bypass_rvalid", {31'b0, rv}, 32'h1);
        checkOutput("bypass_ir_pc", ir_pc, 32'h300);
        checkOutput("bypass_imm12", {20'b0, imm12}, 32'h300);
        loadWhenReady("bypass_next", rv);
        checkOutput("bypass_next_ir_pc", ir_pc, 32'h304);

        // Asynchronous reset in the middle of fetching
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_imem_req", {31'b0, mif.imem_req}, 32'h0);
        checkOutput("arst_ir_valid", {31'b0, ir_valid}, 32'h0);
        checkOutput("arst_ir_pc", ir_pc, 32'h0);
        checkOutput("arst_opcode", {25'b0, opcode}, 32'h40);
        checkOutput("arst_imm12", {20'b0, imm12}, 32'h0);
        checkOutput("arst_buf_empty", {31'b0, buf_empty}, 32'h1);
        lat = 1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;

        // Decode table
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], 32'h1000 + 32'(i) * 32'h100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
